// File: rtl/axi_write_channel_gen.sv
// AXI write-channel master engine.
// Local commands are queued in a small descriptor ring. Four wrapping pointers
// track each burst through the AW issue, W streaming and B collection phases.
// W data passes through combinationally. wlast is generated from a beat counter.
// B responses are matched in order against the stored IDs.
module axi_write_channel_gen #(
    parameter int AW      = 32,
    parameter int DW      = 64,
    parameter int IDW     = 4,
    parameter int MAX_OUT = 4
) (
    input  logic                         clk,
    input  logic                         resetn,

    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [AW-1:0]                cmd_addr,
    input  logic [7:0]                   cmd_len,
    input  logic [2:0]                   cmd_size,
    input  logic [1:0]                   cmd_burst,
    input  logic [IDW-1:0]               cmd_id,

    input  logic [DW-1:0]                wdata_in,
    input  logic [DW/8-1:0]              wstrb_in,
    input  logic                         wvalid_in,
    output logic                         wready_out,

    output logic [IDW-1:0]               m_axi_awid,
    output logic [AW-1:0]                m_axi_awaddr,
    output logic [7:0]                   m_axi_awlen,
    output logic [2:0]                   m_axi_awsize,
    output logic [1:0]                   m_axi_awburst,
    output logic                         m_axi_awvalid,
    input  logic                         m_axi_awready,

    output logic [DW-1:0]                m_axi_wdata,
    output logic [DW/8-1:0]              m_axi_wstrb,
    output logic                         m_axi_wlast,
    output logic                         m_axi_wvalid,
    input  logic                         m_axi_wready,

    input  logic [IDW-1:0]               m_axi_bid,
    input  logic [1:0]                   m_axi_bresp,
    input  logic                         m_axi_bvalid,
    output logic                         m_axi_bready,

    output logic                         done_valid,
    output logic [IDW-1:0]               done_id,
    output logic [1:0]                   done_resp,

    output logic                         err_sticky,
    input  logic                         err_clr,
    output logic [$clog2(MAX_OUT):0]     outstanding
);

    localparam int IW = $clog2(MAX_OUT);
    localparam int PW = IW + 1;
    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [PW-1:0] MAX_CNT = PW'(MAX_OUT);

    // Descriptor ring storage (data only, never reset)
    logic [AW-1:0]  addr_mem  [MAX_OUT];
    logic [7:0]     len_mem   [MAX_OUT];
    logic [2:0]     size_mem  [MAX_OUT];
    logic [1:0]     burst_mem [MAX_OUT];
    logic [IDW-1:0] id_mem    [MAX_OUT];

    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  aw_ptr;
    logic [PW-1:0]  w_ptr;
    logic [PW-1:0]  b_ptr;
    logic [7:0]     beat;
    logic [PW-1:0]  occ;

    logic           cmd_hs;
    logic           aw_hs;
    logic           w_hs;
    logic           wlast_hs;
    logic           b_hs;
    logic           w_active;
    logic           b_err;

    logic           done_vld_p1;
    logic [IDW-1:0] done_id_p1;
    logic [1:0]     done_resp_p1;
    logic           err_q;

    // Occupancy and handshake decode
    always_comb begin
        occ           = wr_ptr - b_ptr;
        cmd_ready     = (occ < MAX_CNT);
        cmd_hs        = cmd_valid & cmd_ready;

        m_axi_awvalid = (aw_ptr != wr_ptr);
        m_axi_awid    = id_mem[aw_ptr[IW-1:0]];
        m_axi_awaddr  = addr_mem[aw_ptr[IW-1:0]];
        m_axi_awlen   = len_mem[aw_ptr[IW-1:0]];
        m_axi_awsize  = size_mem[aw_ptr[IW-1:0]];
        m_axi_awburst = burst_mem[aw_ptr[IW-1:0]];
        aw_hs         = m_axi_awvalid & m_axi_awready;

        // A burst may only stream data once its address has been accepted
        w_active      = (w_ptr != aw_ptr);
        m_axi_wvalid  = wvalid_in & w_active;
        wready_out    = m_axi_wready & w_active;
        m_axi_wdata   = wdata_in;
        m_axi_wstrb   = wstrb_in;
        m_axi_wlast   = w_active & (beat == len_mem[w_ptr[IW-1:0]]);
        w_hs          = m_axi_wvalid & m_axi_wready;
        wlast_hs      = w_hs & m_axi_wlast;

        m_axi_bready  = (b_ptr != w_ptr);
        b_hs          = m_axi_bvalid & m_axi_bready;
        b_err         = b_hs & (m_axi_bresp[1] | (m_axi_bid != id_mem[b_ptr[IW-1:0]]));

        outstanding   = occ;
    end

    // Capture an accepted descriptor into the ring slot at wr_ptr
    always_ff @(posedge clk) begin
        if (cmd_hs) begin
            addr_mem[wr_ptr[IW-1:0]]  <= cmd_addr;
            len_mem[wr_ptr[IW-1:0]]   <= cmd_len;
            size_mem[wr_ptr[IW-1:0]]  <= cmd_size;
            burst_mem[wr_ptr[IW-1:0]] <= cmd_burst;
            id_mem[wr_ptr[IW-1:0]]    <= cmd_id;
        end
    end

    // Ring pointers and the per-burst beat counter
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            aw_ptr <= '0;
            w_ptr  <= '0;
            b_ptr  <= '0;
            beat   <= '0;
        end else begin
            if (cmd_hs) wr_ptr <= wr_ptr + PTR_ONE;
            if (aw_hs)  aw_ptr <= aw_ptr + PTR_ONE;
            if (b_hs)   b_ptr  <= b_ptr + PTR_ONE;
            if (wlast_hs) begin
                beat  <= '0;
                w_ptr <= w_ptr + PTR_ONE;
            end else if (w_hs) begin
                beat  <= beat + 8'd1;
            end
        end
    end

    // Completion valid and sticky error flag; a new error beats a clear
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            done_vld_p1 <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            done_vld_p1 <= b_hs;
            if (b_err)        err_q <= 1'b1;
            else if (err_clr) err_q <= 1'b0;
        end
    end

    // Completion payload, qualified by done_vld_p1
    always_ff @(posedge clk) begin
        if (b_hs) begin
            done_id_p1   <= id_mem[b_ptr[IW-1:0]];
            done_resp_p1 <= m_axi_bresp;
        end
    end

    assign done_valid = done_vld_p1;
    assign done_id    = done_id_p1;
    assign done_resp  = done_resp_p1;
    assign err_sticky = err_q;

endmodule
